// File: rtl/char_pkg.sv
// Purpose: class codes, the default idle byte and the byte classifier shared by the feeder and the recognizer.
// Latency: n/a (types, constants and a pure combinational function).
// Backpressure: n/a.
package char_pkg;

  // Two-bit class code carried alongside every character; 2'b11 is never produced.
  typedef enum logic [1:0] {
    CLS_OTHER  = 2'b00,
    CLS_LETTER = 2'b01,
    CLS_DIGIT  = 2'b10
  } char_class_e;

  // Filler byte emitted while no data is buffered; the recognizer treats it as OTHER.
  localparam logic [7:0] DEFAULT_IDLE_CHAR = 8'h00;

  // ASCII letters and digits get their own class; everything else, including
  // any byte with the top bit set, falls into OTHER.
  function automatic char_class_e classify(input logic [7:0] b);
    char_class_e c;
    c = CLS_OTHER;
    if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A)) begin
      c = CLS_LETTER;
    end else if (b >= 8'h30 && b <= 8'h39) begin
      c = CLS_DIGIT;
    end
    return c;
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Purpose: byte FIFO that drains its head every cycle it holds data.
// Latency: a byte written at edge N can be popped at edge N+1 at the earliest.
// Backpressure: writes are refused while full, even if a pop frees a slot in the same cycle.
module char_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_wr_vld,
  input  logic [7:0]                   i_wr_dat,
  output logic                         o_pop,
  output logic [7:0]                   o_head,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;

  // Full is judged on the registered count only, so a same-cycle pop never lets a write in.
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_wr_vld && !o_full;
  assign o_pop   = !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage is not reset; the pointers and count decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_dat;
    end
  end

  // Pointers wrap independently (DEPTH is a power of two); count tracks push minus pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (o_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, o_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/char_feeder.sv
// Purpose: buffers a bursty byte stream and feeds one classified character per cycle to the recognizer (optional CHAR_FOLD_EN lowercases A-Z on output).
// Latency: byte accepted at edge N appears on char_out after edge N+1; idle filler whenever the FIFO is empty.
// Backpressure: in_ready = !full from the registered count; the downstream side never stalls.
module char_feeder
  import char_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] IDLE_CHAR = DEFAULT_IDLE_CHAR
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [7:0]                  char_out,
  output logic                        char_valid,
  output logic [1:0]                  char_class,
  output logic [$clog2(DEPTH+1)-1:0]  level
);

  logic                        w_pop;
  logic [7:0]                  w_head;
  logic                        w_full;
  logic                        w_empty;
  logic [$clog2(DEPTH+1)-1:0]  w_count;
  logic [7:0]                  w_char;
  char_class_e                 w_class;

  logic [7:0]  r_char_out;
  logic        r_char_valid;
  char_class_e r_char_class;

  char_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .i_wr_vld (in_valid),
    .i_wr_dat (in_data),
    .o_pop    (w_pop),
    .o_head   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_count)
  );

  assign in_ready   = !w_full;
  assign level      = w_count;
  assign char_out   = r_char_out;
  assign char_valid = r_char_valid;
  assign char_class = r_char_class;

  // Classify and (optionally) fold the FIFO head; folding never changes the class.
  always_comb begin
    w_class = classify(w_head);
    w_char  = w_head;
`ifdef CHAR_FOLD_EN
    if (w_head >= 8'h41 && w_head <= 8'h5A) begin
      w_char = w_head + 8'h20;
    end
`else
    // Output is the stored byte untouched.
`endif
  end

  // Output register: load the head on every pop, otherwise emit the idle filler.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_char_out   <= IDLE_CHAR;
      r_char_valid <= 1'b0;
      r_char_class <= CLS_OTHER;
    end else if (w_pop) begin
      r_char_out   <= w_char;
      r_char_valid <= 1'b1;
      r_char_class <= w_class;
    end else begin
      r_char_out   <= IDLE_CHAR;
      r_char_valid <= 1'b0;
      r_char_class <= CLS_OTHER;
    end
  end

  // w_empty is the complement of w_pop; kept as a named net for readability of the FIFO interface.
  logic w_unused;
  assign w_unused = w_empty;

endmodule

// File: tb/tb_char_feeder.sv
module tb_char_feeder;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam logic [7:0] IDLE = 8'h00;

  logic          clk;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    char_out;
  logic          char_valid;
  logic [1:0]    char_class;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of buffered bytes plus logs of what went in and came out.
  logic [7:0] q[$];
  logic [7:0] sent_log[$];
  logic [7:0] out_log[$];

  char_feeder #(.DEPTH(DEPTH), .IDLE_CHAR(IDLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_class (char_class),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] ref_class(input logic [7:0] b);
    if ((b >= "a" && b <= "z") || (b >= "A" && b <= "Z")) return 2'b01;
    if (b >= "0" && b <= "9") return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [7:0] ref_out(input logic [7:0] b);
`ifdef CHAR_FOLD_EN
    if (b >= "A" && b <= "Z") return b + 8'd32;
`endif
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a negedge. Checks the combinational
  // outputs before the edge and the registered outputs after it.
  task automatic do_cycle(input bit v, input logic [7:0] d, output bit acc);
    bit         pop;
    logic [7:0] e_out;
    logic [1:0] e_cls;
    int         sz;
    in_valid = v;
    in_data  = d;
    sz = q.size();
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, (sz < DEPTH)});
    check("level", 32'(level), 32'(sz));
    pop   = (sz > 0);
    acc   = v && (sz < DEPTH);
    e_out = IDLE;
    e_cls = 2'b00;
    if (pop) begin
      e_out = ref_out(q[0]);
      e_cls = ref_class(q[0]);
      out_log.push_back(q.pop_front());
    end
    if (acc) begin
      q.push_back(d);
      sent_log.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
    check("char_out", 32'(char_out), 32'(e_out));
    check("char_valid", {31'd0, char_valid}, {31'd0, pop});
    check("char_class", 32'(char_class), 32'(e_cls));
  endtask

  task automatic idle_cycles(input int n);
    bit acc;
    for (int i = 0; i < n; i++) do_cycle(1'b0, 8'($urandom), acc);
  endtask

  // Hold a byte on in_valid until the handshake completes, bounded.
  task automatic send_byte(input logic [7:0] d);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      do_cycle(1'b1, d, acc);
      tries++;
    end
    check("accept_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic send_string(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic do_reset(input bit v, input logic [7:0] d);
    reset    = 1'b1;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    sent_log.delete();
    out_log.delete();
    check("rst_char_out", 32'(char_out), 32'(IDLE));
    check("rst_char_valid", {31'd0, char_valid}, 32'd0);
    check("rst_char_class", 32'(char_class), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  // Drain the model and DUT, then compare the complete output stream with the input stream.
  task automatic drain_and_compare(input string tag);
    idle_cycles(DEPTH + 3);
    check({tag, "_len"}, 32'(out_log.size()), 32'(sent_log.size()));
    for (int i = 0; i < sent_log.size() && i < out_log.size(); i++) begin
      check({tag, "_byte"}, 32'(out_log[i]), 32'(sent_log[i]));
    end
    check({tag, "_level"}, 32'(level), 32'd0);
    sent_log.delete();
    out_log.delete();
  endtask

  initial begin
    bit         acc;
    logic [7:0] base;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);

    // Reset with a byte offered: it must not be accepted.
    do_reset(1'b1, "z");
    idle_cycles(5);

    // Two characters back to back, then idle.
    send_string("a1");
    idle_cycles(3);
    drain_and_compare("a1");

    // Continuous uppercase stream.
    send_string("ABCDEFGH");
    drain_and_compare("upper");

    // Mixed classes and classification boundaries.
    send_string("x9_#");
    send_byte(8'hC1);
    send_byte(8'hE1);
    send_string("@[`{/:09azAZ");
    drain_and_compare("bounds");

    // Pointer wrap: 19 distinct bytes with random gaps.
    base = 8'($urandom);
    for (int i = 0; i < 19; i++) begin
      while ($urandom_range(0, 2) == 0) do_cycle(1'b0, 8'($urandom), acc);
      send_byte(base + 8'(i));
    end
    drain_and_compare("wrap");

    // Long random run with random valid.
    for (int i = 0; i < 200; i++) do_cycle(1'($urandom_range(0, 1)), 8'($urandom), acc);
    drain_and_compare("random");

    // Reset while data is buffered: stale bytes must never appear.
    send_string("QR");
    check("pre_reset_level", 32'(level), 32'd1);
    do_reset(1'b1, "S");
    idle_cycles(4);
    send_string("k7");
    drain_and_compare("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
